nh_lcd_bus_arbiter: RTL and testbench

NH_LCD_BUS_ARBITER -- requirements
Module: nh_lcd_bus_arbiter

---
 rtl/nh_lcd_defines.sv | 56 +++++
 rtl/nh_lcd_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_nh_lcd_bus_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nh_lcd_defines.sv
// Shared LCD interface definitions: controller command bytes, bus arbiter
// state encodings and the parked (idle) bus levels.
package nh_lcd_defines;

   // Controller command opcodes used by the command path
   localparam logic [7:0] CMD_NOP     = 8'h00;
   localparam logic [7:0] CMD_SWRESET = 8'h01;
   localparam logic [7:0] CMD_SLPOUT  = 8'h11;
   localparam logic [7:0] CMD_DISPON  = 8'h29;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_RASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;

   // Arbiter states; the encoding is exported on the debug bus
   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GNT_CMD = 2'd1,
      ARB_GNT_DAT = 2'd2,
      ARB_TURN    = 2'd3
   } arb_state_e;

   localparam logic OWNER_CMD = 1'b0;
   localparam logic OWNER_DAT = 1'b1;

   // Bus levels while nobody owns it: command mode, no strobes, not driving
   localparam logic       PARK_CMD_MODE    = 1'b1;
   localparam logic       PARK_WRITE       = 1'b0;
   localparam logic       PARK_READ        = 1'b0;
   localparam logic       PARK_DATA_OUT_EN = 1'b0;
   localparam logic [7:0] PARK_DATA_OUT    = 8'h00;

   // Grant decision taken in IDLE. A tie goes to data when data has fixed
   // priority, otherwise to whichever requester did not own the bus last.
   function automatic arb_state_e arb_pick(
      input logic cmd_req,
      input logic dat_req,
      input logic prio_data,
      input logic last_owner
   );
      arb_state_e pick;
      pick = ARB_IDLE;
      if (cmd_req && dat_req) begin
         if (prio_data || (last_owner == OWNER_CMD)) begin
            pick = ARB_GNT_DAT;
         end else begin
            pick = ARB_GNT_CMD;
         end
      end else if (cmd_req) begin
         pick = ARB_GNT_CMD;
      end else if (dat_req) begin
         pick = ARB_GNT_DAT;
      end
      return pick;
   endfunction

endpackage

// File: rtl/nh_lcd_bus_arbiter.sv
// Shares the physical LCD bus between the command path and the pixel
// data writer. Grants are registered, never preempted, and every handover
// passes through a parked turnaround window.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | bus parked; arbitrate when enabled
//   GNT_CMD  | command path owns the bus; its controls pass straight through
//   GNT_DAT  | data writer owns the bus; its controls pass straight through
//   TURN     | bus parked; counter runs down to 0, then back to IDLE
module nh_lcd_bus_arbiter
   import nh_lcd_defines::*;
#(
   parameter int TURNAROUND = 1,
   parameter bit PRIO_DATA  = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_enable,

   input  logic        i_cmd_req,
   output logic        o_cmd_gnt,
   input  logic        i_cmd_cmd_mode,
   input  logic        i_cmd_write,
   input  logic        i_cmd_read,
   input  logic        i_cmd_data_out_en,
   input  logic [7:0]  i_cmd_data_out,
   output logic [7:0]  o_cmd_data_in,

   input  logic        i_dat_req,
   output logic        o_dat_gnt,
   input  logic        i_dat_cmd_mode,
   input  logic        i_dat_write,
   input  logic        i_dat_read,
   input  logic        i_dat_data_out_en,
   input  logic [7:0]  i_dat_data_out,
   output logic [7:0]  o_dat_data_in,

   output logic        o_cmd_mode,
   output logic        o_write,
   output logic        o_read,
   output logic        o_data_out_en,
   output logic [7:0]  o_data_out,
   input  logic [7:0]  i_data_in,

   output logic [31:0] debug
);

   // Out-of-range settings are clamped so the 4-bit counter stays meaningful
   localparam int TURN_CLAMPED = (TURNAROUND < 1)  ? 1 :
                                 (TURNAROUND > 15) ? 15 : TURNAROUND;
   localparam logic [3:0] TURN_LOAD = 4'(TURN_CLAMPED - 1);

   arb_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       last_owner_q, last_owner_d;
   logic       cmd_gnt_q, dat_gnt_q;
   arb_state_e pick;

   // State, turnaround counter, round-robin history and registered grants
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         cnt_q        <= 4'd0;
         last_owner_q <= OWNER_DAT;
         cmd_gnt_q    <= 1'b0;
         dat_gnt_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_owner_q <= last_owner_d;
         cmd_gnt_q    <= (state_d == ARB_GNT_CMD);
         dat_gnt_q    <= (state_d == ARB_GNT_DAT);
      end
   end

   // Next state: arbitrate only from IDLE, release only when the owner drops req
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_owner_d = last_owner_q;
      pick         = arb_pick(i_cmd_req, i_dat_req, PRIO_DATA, last_owner_q);
      case (state_q)
         ARB_IDLE: begin
            if (i_enable) begin
               if (pick == ARB_GNT_CMD) begin
                  state_d      = ARB_GNT_CMD;
                  last_owner_d = OWNER_CMD;
               end else if (pick == ARB_GNT_DAT) begin
                  state_d      = ARB_GNT_DAT;
                  last_owner_d = OWNER_DAT;
               end
            end
         end
         ARB_GNT_CMD: begin
            if (!i_cmd_req) begin
               state_d = ARB_TURN;
               cnt_d   = TURN_LOAD;
            end
         end
         ARB_GNT_DAT: begin
            if (!i_dat_req) begin
               state_d = ARB_TURN;
               cnt_d   = TURN_LOAD;
            end
         end
         ARB_TURN: begin
            if (cnt_q == 4'd0) begin
               state_d = ARB_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Bus mux: owner's controls pass through with no added latency, else parked
   always_comb begin
      o_cmd_mode    = PARK_CMD_MODE;
      o_write       = PARK_WRITE;
      o_read        = PARK_READ;
      o_data_out_en = PARK_DATA_OUT_EN;
      o_data_out    = PARK_DATA_OUT;
      case (state_q)
         ARB_GNT_CMD: begin
            o_cmd_mode    = i_cmd_cmd_mode;
            o_write       = i_cmd_write;
            o_read        = i_cmd_read;
            o_data_out_en = i_cmd_data_out_en;
            o_data_out    = i_cmd_data_out;
         end
         ARB_GNT_DAT: begin
            o_cmd_mode    = i_dat_cmd_mode;
            o_write       = i_dat_write;
            o_read        = i_dat_read;
            o_data_out_en = i_dat_data_out_en;
            o_data_out    = i_dat_data_out;
         end
         default: begin
         end
      endcase
   end

   assign o_cmd_gnt     = cmd_gnt_q;
   assign o_dat_gnt     = dat_gnt_q;
   assign o_cmd_data_in = i_data_in;
   assign o_dat_data_in = i_data_in;
   assign debug         = {27'd0, i_dat_req, i_cmd_req, last_owner_q, state_q};

endmodule

// File: tb/tb_nh_lcd_bus_arbiter.sv
// Bench for nh_lcd_bus_arbiter. Three instances share the stimulus:
// u_rr1 (round-robin, turnaround 1), u_rr3 (round-robin, turnaround 3),
// u_pd1 (data priority, turnaround 1). Each test only inspects the one
// instance it targets.
module tb_nh_lcd_bus_arbiter;

   localparam int T_LONG = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en;
   logic       cmd_req, cmd_mode, cmd_wr, cmd_rd, cmd_oe;
   logic [7:0] cmd_byte;
   logic       dat_req, dat_mode, dat_wr, dat_rd, dat_oe;
   logic [7:0] dat_byte;
   logic [7:0] din;

   logic        cmd_gnt  [3];
   logic        dat_gnt  [3];
   logic        bus_mode [3];
   logic        bus_wr   [3];
   logic        bus_rd   [3];
   logic        bus_oe   [3];
   logic [7:0]  bus_dout [3];
   logic [7:0]  cmd_din  [3];
   logic [7:0]  dat_din  [3];
   logic [31:0] dbg      [3];

   int checks = 0;
   int errors = 0;

   nh_lcd_bus_arbiter #(.TURNAROUND(1), .PRIO_DATA(1'b0)) u_rr1 (
      .clk(clk), .rst(rst), .i_enable(en),
      .i_cmd_req(cmd_req), .o_cmd_gnt(cmd_gnt[0]), .i_cmd_cmd_mode(cmd_mode),
      .i_cmd_write(cmd_wr), .i_cmd_read(cmd_rd), .i_cmd_data_out_en(cmd_oe),
      .i_cmd_data_out(cmd_byte), .o_cmd_data_in(cmd_din[0]),
      .i_dat_req(dat_req), .o_dat_gnt(dat_gnt[0]), .i_dat_cmd_mode(dat_mode),
      .i_dat_write(dat_wr), .i_dat_read(dat_rd), .i_dat_data_out_en(dat_oe),
      .i_dat_data_out(dat_byte), .o_dat_data_in(dat_din[0]),
      .o_cmd_mode(bus_mode[0]), .o_write(bus_wr[0]), .o_read(bus_rd[0]),
      .o_data_out_en(bus_oe[0]), .o_data_out(bus_dout[0]), .i_data_in(din),
      .debug(dbg[0]));

   nh_lcd_bus_arbiter #(.TURNAROUND(T_LONG), .PRIO_DATA(1'b0)) u_rr3 (
      .clk(clk), .rst(rst), .i_enable(en),
      .i_cmd_req(cmd_req), .o_cmd_gnt(cmd_gnt[1]), .i_cmd_cmd_mode(cmd_mode),
      .i_cmd_write(cmd_wr), .i_cmd_read(cmd_rd), .i_cmd_data_out_en(cmd_oe),
      .i_cmd_data_out(cmd_byte), .o_cmd_data_in(cmd_din[1]),
      .i_dat_req(dat_req), .o_dat_gnt(dat_gnt[1]), .i_dat_cmd_mode(dat_mode),
      .i_dat_write(dat_wr), .i_dat_read(dat_rd), .i_dat_data_out_en(dat_oe),
      .i_dat_data_out(dat_byte), .o_dat_data_in(dat_din[1]),
      .o_cmd_mode(bus_mode[1]), .o_write(bus_wr[1]), .o_read(bus_rd[1]),
      .o_data_out_en(bus_oe[1]), .o_data_out(bus_dout[1]), .i_data_in(din),
      .debug(dbg[1]));

   nh_lcd_bus_arbiter #(.TURNAROUND(1), .PRIO_DATA(1'b1)) u_pd1 (
      .clk(clk), .rst(rst), .i_enable(en),
      .i_cmd_req(cmd_req), .o_cmd_gnt(cmd_gnt[2]), .i_cmd_cmd_mode(cmd_mode),
      .i_cmd_write(cmd_wr), .i_cmd_read(cmd_rd), .i_cmd_data_out_en(cmd_oe),
      .i_cmd_data_out(cmd_byte), .o_cmd_data_in(cmd_din[2]),
      .i_dat_req(dat_req), .o_dat_gnt(dat_gnt[2]), .i_dat_cmd_mode(dat_mode),
      .i_dat_write(dat_wr), .i_dat_read(dat_rd), .i_dat_data_out_en(dat_oe),
      .i_dat_data_out(dat_byte), .o_dat_data_in(dat_din[2]),
      .o_cmd_mode(bus_mode[2]), .o_write(bus_wr[2]), .o_read(bus_rd[2]),
      .o_data_out_en(bus_oe[2]), .o_data_out(bus_dout[2]), .i_data_in(din),
      .debug(dbg[2]));

   // ---------------- scoreboard ----------------
   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];

   task automatic sb_push(input string n, input logic [31:0] v);
      exp_t e;
      e.name = n;
      e.val  = v;
      sb_q.push_back(e);
   endtask

   task automatic sb_check(input logic [31:0] act);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got %h with nothing expected", act);
      end else begin
         e = sb_q.pop_front();
         if (act !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
   endtask

   // {cmd_gnt, dat_gnt, cmd_mode, write, read, data_out_en, data_out}
   function automatic logic [31:0] bus_of(input int i);
      return {18'd0, cmd_gnt[i], dat_gnt[i], bus_mode[i], bus_wr[i],
              bus_rd[i], bus_oe[i], bus_dout[i]};
   endfunction

   function automatic logic [31:0] gnt_of(input int i);
      return {30'd0, cmd_gnt[i], dat_gnt[i]};
   endfunction

   localparam logic [31:0] PARKED = {18'd0, 2'b00, 4'b1000, 8'h00};

   // grants must never overlap on any instance
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (cmd_gnt[i] && dat_gnt[i]) begin
               errors++;
               $display("FAIL gnt_exclusive[%0d]: got both grants high, required at most one", i);
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ctl(input logic [3:0] c, input logic [7:0] cb,
                          input logic [3:0] d, input logic [7:0] db);
      {cmd_mode, cmd_wr, cmd_rd, cmd_oe} = c;
      cmd_byte = cb;
      {dat_mode, dat_wr, dat_rd, dat_oe} = d;
      dat_byte = db;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      en      = 1'b1;
      cmd_req = 1'b0;
      dat_req = 1'b0;
      din     = 8'h00;
      set_ctl(4'b0000, 8'h00, 4'b0000, 8'h00);
      step();
      rst = 1'b0;
   endtask

   task automatic rr_rounds(input int i, input logic [3:0] dat_mask, input string tag);
      logic got;
      do_reset();
      cmd_req = 1'b1;
      dat_req = 1'b1;
      for (int r = 0; r < 4; r++) begin
         got = 1'b0;
         for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (cmd_gnt[i] || dat_gnt[i]) got = 1'b1;
         end
         sb_push($sformatf("%s_round%0d", tag, r),
                 {29'd0, 1'b1, dat_mask[r] ? 2'b01 : 2'b10});
         sb_check({29'd0, got, cmd_gnt[i], dat_gnt[i]});
         if (dat_gnt[i]) dat_req = 1'b0;
         else            cmd_req = 1'b0;
         step();
         cmd_req = 1'b1;
         dat_req = 1'b1;
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string       name;
      logic        en;
      logic        cmd_req;
      logic        dat_req;
      logic [3:0]  cmd_ctl;
      logic [7:0]  cmd_byte;
      logic [3:0]  dat_ctl;
      logic [7:0]  dat_byte;
      logic [7:0]  din;
      logic [13:0] exp_bus;
   } vec_t;

   vec_t vecs[6];

   initial begin : main
      logic       got, leak;
      int         gap, turn_cycles;

      vecs[0] = '{"cmd_only",        1'b1, 1'b1, 1'b0, 4'b0101, 8'h3C, 4'b1010, 8'hC3, 8'h5E, {2'b10, 4'b0101, 8'h3C}};
      vecs[1] = '{"dat_only",        1'b1, 1'b0, 1'b1, 4'b0111, 8'hFF, 4'b1101, 8'hA5, 8'h81, {2'b01, 4'b1101, 8'hA5}};
      vecs[2] = '{"tie_first_cmd",   1'b1, 1'b1, 1'b1, 4'b1010, 8'h5A, 4'b0101, 8'hA5, 8'h00, {2'b10, 4'b1010, 8'h5A}};
      vecs[3] = '{"disabled_parked", 1'b0, 1'b1, 1'b1, 4'b0111, 8'h77, 4'b0111, 8'h88, 8'hFF, {2'b00, 4'b1000, 8'h00}};
      vecs[4] = '{"no_req_parked",   1'b1, 1'b0, 1'b0, 4'b0101, 8'h12, 4'b0011, 8'h34, 8'h3A, {2'b00, 4'b1000, 8'h00}};
      vecs[5] = '{"dat_read",        1'b1, 1'b0, 1'b1, 4'b0100, 8'h99, 4'b0010, 8'h00, 8'hC7, {2'b01, 4'b0010, 8'h00}};

      do_reset();

      // reset state
      sb_push("rst_bus", PARKED);
      sb_check(bus_of(0));
      sb_push("rst_debug", 32'h0000_0004);
      sb_check(dbg[0]);

      // table: one grant decision each, then the bus mux and data_in fan-out
      for (int v = 0; v < 6; v++) begin
         do_reset();
         en      = vecs[v].en;
         cmd_req = vecs[v].cmd_req;
         dat_req = vecs[v].dat_req;
         step();
         set_ctl(vecs[v].cmd_ctl, vecs[v].cmd_byte, vecs[v].dat_ctl, vecs[v].dat_byte);
         din = vecs[v].din;
         sb_push(vecs[v].name, {18'd0, vecs[v].exp_bus});
         sb_push({vecs[v].name, "_din"}, {16'd0, vecs[v].din, vecs[v].din});
         #1;
         sb_check(bus_of(0));
         sb_check({16'd0, cmd_din[0], dat_din[0]});
      end

      // first tie after reset goes to cmd, handover to dat after turnaround
      do_reset();
      cmd_req = 1'b1;
      dat_req = 1'b1;
      step();
      sb_push("tie_gnt_cmd", 32'h2);
      sb_check(gnt_of(0));
      sb_push("tie_debug", 32'h19);
      sb_check(dbg[0]);
      set_ctl(4'b0101, 8'h3C, 4'b0000, 8'h00);
      cmd_req = 1'b0;
      step();
      sb_push("handover_turn_bus", PARKED);
      sb_check(bus_of(0));
      sb_push("handover_turn_debug", 32'h13);
      sb_check(dbg[0]);
      step();
      sb_push("handover_idle_debug", 32'h10);
      sb_check(dbg[0]);
      step();
      sb_push("handover_gnt_dat", 32'h1);
      sb_check(gnt_of(0));
      sb_push("handover_debug", 32'h16);
      sb_check(dbg[0]);

      // request dropped in the cycle its grant appears still goes through TURN
      do_reset();
      cmd_req = 1'b1;
      step();
      cmd_req = 1'b0;
      step();
      sb_push("short_req_turn", 32'h3);
      sb_check(dbg[0]);
      step();
      sb_push("short_req_idle", 32'h0);
      sb_check(dbg[0]);

      // non-owner strobes never reach the bus
      do_reset();
      dat_req = 1'b1;
      step();
      for (int k = 0; k < 6; k++) begin
         set_ctl(4'b0101, 8'h11, {1'b1, k[0], 1'b0, 1'b1}, 8'hA5);
         sb_push($sformatf("dat_owner_bus%0d", k), {18'd0, 2'b01, 1'b1, k[0], 1'b0, 1'b1, 8'hA5});
         #1;
         sb_check(bus_of(0));
         step();
      end

      // long turnaround: exactly T_LONG parked TURN cycles, then the arbitration cycle
      do_reset();
      cmd_req = 1'b1;
      step();
      sb_push("long_gnt_cmd", 32'h2);
      sb_check(gnt_of(1));
      dat_req = 1'b1;
      set_ctl(4'b0101, 8'hEE, 4'b1101, 8'h55);
      cmd_req = 1'b0;
      got = 1'b0;
      leak = 1'b0;
      gap = 0;
      turn_cycles = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         step();
         if (dat_gnt[1]) got = 1'b1;
         else begin
            gap++;
            if (dbg[1][1:0] == 2'b11) turn_cycles++;
            leak = leak | bus_wr[1] | bus_oe[1];
         end
      end
      sb_push("long_got_gnt", 32'h1);
      sb_check({31'd0, got});
      sb_push("long_turn_cycles", T_LONG);
      sb_check(turn_cycles);
      sb_push("long_gap_cycles", T_LONG + 1);
      sb_check(gap);
      sb_push("long_gap_parked", 32'h0);
      sb_check({31'd0, leak});
      sb_push("long_dat_bus", {18'd0, 2'b01, 4'b1101, 8'h55});
      sb_check(bus_of(1));

      // disabled: no grant for 10 cycles, grant on the cycle after enable
      do_reset();
      en = 1'b0;
      cmd_req = 1'b1;
      dat_req = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         sb_push($sformatf("disabled_cycle%0d", k), 32'h0);
         sb_check(gnt_of(0));
      end
      en = 1'b1;
      step();
      sb_push("enable_gnt", 32'h2);
      sb_check(gnt_of(0));

      // enable dropping mid-grant leaves the grant alone; no new grant while disabled
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         sb_push($sformatf("en_low_hold%0d", k), 32'h2);
         sb_check(gnt_of(0));
      end
      cmd_req = 1'b0;
      step();
      step();
      step();
      sb_push("en_low_stay_idle", 32'h10);
      sb_check(dbg[0]);

      // reset mid-grant parks the bus on the very next edge
      do_reset();
      dat_req = 1'b1;
      step();
      set_ctl(4'b0000, 8'h00, 4'b0101, 8'h5A);
      #1;
      sb_push("pre_rst_bus", {18'd0, 2'b01, 4'b0101, 8'h5A});
      sb_check(bus_of(0));
      rst = 1'b1;
      step();
      sb_push("mid_grant_rst", PARKED);
      sb_check(bus_of(0));
      rst = 1'b0;

      // back-to-back ties: alternate under round-robin, always data under priority
      rr_rounds(0, 4'b1010, "rr");
      rr_rounds(2, 4'b1111, "prio");

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
   end

endmodule
